// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// FSM states, opcode values and 16-bit instruction field positions.
package instr_fetch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } if_state_e;

   localparam logic [3:0] HALT_OP = 4'hF;
   localparam logic [3:0] JUMP_OP = 4'hE;

   localparam int OP_MSB   = 15;
   localparam int OP_LSB   = 12;
   localparam int DST_MSB  = 11;
   localparam int DST_LSB  = 8;
   localparam int SRC1_MSB = 7;
   localparam int SRC1_LSB = 4;
   localparam int SRC2_MSB = 3;
   localparam int SRC2_LSB = 0;

   function automatic logic [3:0] opcode_of(input logic [15:0] w);
      return w[OP_MSB:OP_LSB];
   endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Bus bundle for the fetch stage: program load port, control, issue outputs.
// master = driver of load/start/stall; slave = the fetch stage itself.
interface instr_fetch_if #(
   parameter int ADDR_W = 6
);
   logic              load_en;
   logic [ADDR_W-1:0] load_addr;
   logic [15:0]       load_data;
   logic              start;
   logic              stall;
   logic [15:0]       instr;
   logic              instr_valid;
   logic [ADDR_W-1:0] pc;
   logic              busy;
   logic              halted;

   modport master (
      output load_en, load_addr, load_data, start, stall,
      input  instr, instr_valid, pc, busy, halted
   );

   modport slave (
      input  load_en, load_addr, load_data, start, stall,
      output instr, instr_valid, pc, busy, halted
   );
endinterface

// File: rtl/instr_fetch_mem.sv
// Program memory: 2^ADDR_W x 16, synchronous write, asynchronous read.
// Ports: clk, we/waddr/wdata write port, raddr/rdata read port. No reset.
module instr_mem #(
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [15:0]       wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [15:0]       rdata
);
   logic [15:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];
endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: IDLE/RUN/HALT FSM issuing one 16-bit word per unstalled cycle.
// Ports: clk, reset (async active-low), bus (instr_fetch_if.slave). Macro: IF_JUMP_EN.
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter int         ADDR_W  = 6,
   parameter logic [3:0] P_HALT  = HALT_OP,
   parameter logic [3:0] P_JUMP  = JUMP_OP
) (
   input  logic         clk,
   input  logic         reset,
   instr_fetch_if.slave bus
);
   if_state_e         state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [15:0]       instr_q, instr_d;
   logic              valid_q, valid_d;
   logic [15:0]       word;
   logic              mem_we;

   // Writes in RUN would race the fetch stream, so they are dropped.
   assign mem_we = bus.load_en && (state_q != ST_RUN);

   instr_mem #(.ADDR_W(ADDR_W)) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .waddr (bus.load_addr),
      .wdata (bus.load_data),
      .raddr (pc_q),
      .rdata (word)
   );

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      valid_d = 1'b0;
      unique case (state_q)
         ST_IDLE, ST_HALT: begin
            if (bus.start) begin
               state_d = ST_RUN;
               pc_d    = '0;
            end
         end
         ST_RUN: begin
            if (!bus.stall) begin
               if (opcode_of(word) == P_HALT) begin
                  state_d = ST_HALT;
`ifdef IF_JUMP_EN
               end else if (opcode_of(word) == P_JUMP) begin
                  pc_d = word[ADDR_W-1:0];
`endif
               end else begin
                  instr_d = word;
                  valid_d = 1'b1;
                  pc_d    = pc_q + ADDR_W'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         pc_q    <= '0;
         instr_q <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
      end
   end

   assign bus.instr       = instr_q;
   assign bus.instr_valid = valid_q;
   assign bus.pc          = pc_q;
   assign bus.busy        = (state_q == ST_RUN);
   assign bus.halted      = (state_q == ST_HALT);
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: issue, stall, load gating, reset, wrap, jump.
// Two instances: ADDR_W=6 for most cases, ADDR_W=2 for pc wrap-around.
module tb_instr_fetch;
   logic clk;
   logic reset;
   int   n_chk;
   int   n_pass;

   instr_fetch_if #(.ADDR_W(6)) bus ();
   instr_fetch_if #(.ADDR_W(2)) bw ();

   instr_fetch #(.ADDR_W(6)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   instr_fetch #(.ADDR_W(2)) dut_w (
      .clk   (clk),
      .reset (reset),
      .bus   (bw)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] got,
                      input logic [15:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [5:0] a, input logic [15:0] d);
      bus.load_en   = 1'b1;
      bus.load_addr = a;
      bus.load_data = d;
      tick();
      bus.load_en   = 1'b0;
   endtask

   task automatic go();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic issue(input string tag, input logic [15:0] ins,
                        input logic [15:0] pcx);
      chk({tag, "_v"}, 16'(bus.instr_valid), 16'h1);
      chk({tag, "_i"}, bus.instr, ins);
      chk({tag, "_pc"}, 16'(bus.pc), pcx);
   endtask

   initial begin
      n_chk = 0;
      n_pass = 0;
      reset = 1'b0;
      bus.load_en = 0; bus.load_addr = 0; bus.load_data = 0;
      bus.start = 0; bus.stall = 0;
      bw.load_en = 0; bw.load_addr = 0; bw.load_data = 0;
      bw.start = 0; bw.stall = 0;
      #3;
      chk("rst_pc", 16'(bus.pc), 16'h0);
      chk("rst_instr", bus.instr, 16'h0);
      chk("rst_valid", 16'(bus.instr_valid), 16'h0);
      chk("rst_busy", 16'(bus.busy), 16'h0);
      chk("rst_halted", 16'(bus.halted), 16'h0);
      #4 reset = 1'b1;

      // sequential issue
      load(6'd0, 16'h1123);
      load(6'd1, 16'h2456);
      load(6'd2, 16'hF000);
      go();
      chk("seq_busy", 16'(bus.busy), 16'h1);
      chk("seq_e0_v", 16'(bus.instr_valid), 16'h0);
      chk("seq_e0_pc", 16'(bus.pc), 16'h0);
      tick();
      issue("seq1", 16'h1123, 16'h1);
      tick();
      issue("seq2", 16'h2456, 16'h2);
      tick();
      chk("seq_halt", 16'(bus.halted), 16'h1);
      chk("seq_halt_v", 16'(bus.instr_valid), 16'h0);
      chk("seq_halt_pc", 16'(bus.pc), 16'h2);
      chk("seq_halt_i", bus.instr, 16'h2456);
      tick();
      chk("halt_stay", 16'(bus.halted), 16'h1);

      // stall
      go();
      tick();
      issue("st1", 16'h1123, 16'h1);
      bus.stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("st_v", 16'(bus.instr_valid), 16'h0);
         chk("st_pc", 16'(bus.pc), 16'h1);
         chk("st_i", bus.instr, 16'h1123);
      end
      bus.stall = 1'b0;
      tick();
      issue("st2", 16'h2456, 16'h2);
      tick();
      chk("st_halt", 16'(bus.halted), 16'h1);
      chk("st_halt_v", 16'(bus.instr_valid), 16'h0);

      // load gating in RUN, reload in HALT
      go();
      bus.load_en = 1'b1;
      bus.load_addr = 6'd2;
      bus.load_data = 16'h1111;
      tick();
      bus.load_en = 1'b0;
      issue("lg1", 16'h1123, 16'h1);
      tick();
      issue("lg2", 16'h2456, 16'h2);
      tick();
      chk("lg_halt", 16'(bus.halted), 16'h1);
      chk("lg_halt_i", bus.instr, 16'h2456);
      load(6'd0, 16'h3789);
      go();
      tick();
      issue("rs1", 16'h3789, 16'h1);
      tick();
      tick();
      chk("rs_halt", 16'(bus.halted), 16'h1);

      // load and start together
      bus.load_en = 1'b1;
      bus.load_addr = 6'd0;
      bus.load_data = 16'h1555;
      go();
      bus.load_en = 1'b0;
      tick();
      issue("ls1", 16'h1555, 16'h1);
      tick();
      tick();
      chk("ls_halt", 16'(bus.halted), 16'h1);

      // jump
      load(6'd0, 16'hE005);
      load(6'd5, 16'h1ABC);
      load(6'd6, 16'hF000);
      go();
      tick();
`ifdef IF_JUMP_EN
      chk("jmp_bub_v", 16'(bus.instr_valid), 16'h0);
      chk("jmp_bub_pc", 16'(bus.pc), 16'h5);
      tick();
      issue("jmp1", 16'h1ABC, 16'h6);
      tick();
      chk("jmp_halt", 16'(bus.halted), 16'h1);
      chk("jmp_halt_pc", 16'(bus.pc), 16'h6);
`else
      issue("nj1", 16'hE005, 16'h1);
      tick();
      issue("nj2", 16'h2456, 16'h2);
      tick();
      chk("nj_halt", 16'(bus.halted), 16'h1);
`endif

      // reset mid-run
      load(6'd0, 16'h1123);
      load(6'd2, 16'h1777);
      load(6'd3, 16'hF000);
      go();
      tick();
      tick();
      chk("mr_pc", 16'(bus.pc), 16'h2);
      chk("mr_busy", 16'(bus.busy), 16'h1);
      #2 reset = 1'b0;
      #1;
      chk("mr_rst_pc", 16'(bus.pc), 16'h0);
      chk("mr_rst_i", bus.instr, 16'h0);
      chk("mr_rst_v", 16'(bus.instr_valid), 16'h0);
      chk("mr_rst_busy", 16'(bus.busy), 16'h0);
      chk("mr_rst_halt", 16'(bus.halted), 16'h0);
      #3 reset = 1'b1;
      go();
      tick();
      issue("mr1", 16'h1123, 16'h1);
      tick();
      issue("mr2", 16'h2456, 16'h2);
      tick();
      issue("mr3", 16'h1777, 16'h3);
      tick();
      chk("mr_halt", 16'(bus.halted), 16'h1);
      chk("mr_halt_pc", 16'(bus.pc), 16'h3);

      // wrap-around on ADDR_W=2 instance
      for (int a = 0; a < 4; a++) begin
         bw.load_en = 1'b1;
         bw.load_addr = 2'(a);
         bw.load_data = 16'h1000;
         tick();
      end
      bw.load_en = 1'b0;
      bw.start = 1'b1;
      tick();
      bw.start = 1'b0;
      begin
         logic [15:0] exp_pc [6];
         exp_pc = '{16'h1, 16'h2, 16'h3, 16'h0, 16'h1, 16'h2};
         for (int i = 0; i < 6; i++) begin
            tick();
            chk("wr_pc", 16'(bw.pc), exp_pc[i]);
            chk("wr_v", 16'(bw.instr_valid), 16'h1);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
